// File: rtl/vga_timing_if.sv
// Raster timing bundle carried from the timing generator to every renderer.
// The generator drives it through master; renderers consume it through slave.
interface vga_timing_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output DrawX,
        output DrawY,
        output hs,
        output vs,
        output blank,
        output line_start,
        output frame_start,
        output frame_count
    );

    modport slave (
        input DrawX,
        input DrawY,
        input hs,
        input vs,
        input blank,
        input line_start,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing generator: horizontal/vertical counters, sync pulses,
// display enable and per-line/per-frame strobes, all decoded in the counter's cycle.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic         vga_clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Compared at 11 bits so a sync window ending exactly at 1024 stays correct.
    localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (H_TOTAL < 1) || (V_TOTAL < 1)) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must lie in 1..1024");
    end

    logic [9:0]  hc_q;
    logic [9:0]  hc_d;
    logic [9:0]  vc_q;
    logic [9:0]  vc_d;
    logic [15:0] frame_count_q;
    logic [15:0] frame_count_d;

    logic        h_sync_s;
    logic        v_sync_s;
    logic        visible_s;

    // Raster advance: hc every clock, vc and frame_count on the wraps.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        frame_count_d = frame_count_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            if (vc_q == V_LAST) begin
                vc_d          = 10'd0;
                frame_count_d = frame_count_q + 16'd1;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end else begin
            hc_d = hc_q + 10'd1;
        end
    end

    // Counter state; reset abandons the current frame without counting it.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            frame_count_q <= 16'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Same-cycle decode of the raster position into sync/enable/strobes.
    always_comb begin
        h_sync_s  = ({1'b0, hc_q} >= H_SYNC_START) && ({1'b0, hc_q} < H_SYNC_END);
        v_sync_s  = ({1'b0, vc_q} >= V_SYNC_START) && ({1'b0, vc_q} < V_SYNC_END);
        visible_s = ({1'b0, hc_q} < H_VIS_END) && ({1'b0, vc_q} < V_VIS_END);

        vga.frame_count = frame_count_q;
        if (reset) begin
            vga.DrawX       = 10'd0;
            vga.DrawY       = 10'd0;
            vga.hs          = ~SYNC_POL;
            vga.vs          = ~SYNC_POL;
            vga.blank       = 1'b0;
            vga.line_start  = 1'b0;
            vga.frame_start = 1'b0;
        end else begin
            vga.DrawX       = hc_q;
            vga.DrawY       = vc_q;
            vga.hs          = h_sync_s ? SYNC_POL : ~SYNC_POL;
            vga.vs          = v_sync_s ? SYNC_POL : ~SYNC_POL;
            vga.blank       = visible_s;
            vga.line_start  = (hc_q == 10'd0);
            vga.frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 line timing, a reduced raster
// for whole-frame and mid-frame reset behaviour, and a 1x1 raster for counter wrap.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def  = 1'b1;
    logic rst_med  = 1'b1;
    logic rst_tiny = 1'b1;

    vga_timing_if vif_def ();
    vga_timing_if vif_med ();
    vga_timing_if vif_tiny ();

    vga_timing_gen u_def (
        .vga_clk (clk),
        .reset   (rst_def),
        .vga     (vif_def)
    );

    // 24 x 18 raster: hsync on x 18..21, vsync on lines 14..15, visible 16 x 12.
    vga_timing_gen #(
        .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (2),
        .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
        .SYNC_POL  (1'b0)
    ) u_med (
        .vga_clk (clk),
        .reset   (rst_med),
        .vga     (vif_med)
    );

    // 1 x 1 raster: every clock completes a frame.
    vga_timing_gen #(
        .H_VISIBLE (1), .H_FRONT (0), .H_SYNC (0), .H_BACK (0),
        .V_VISIBLE (1), .V_FRONT (0), .V_SYNC (0), .V_BACK (0),
        .SYNC_POL  (1'b0)
    ) u_tiny (
        .vga_clk (clk),
        .reset   (rst_tiny),
        .vga     (vif_tiny)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int hs_low;
        int vs_low;
        int glitch;

        // ---------------- default 640x480 instance ----------------
        repeat (3) @(negedge clk);
        #1;
        chk("rst_drawx", 32'(vif_def.DrawX), 32'd0);
        chk("rst_drawy", 32'(vif_def.DrawY), 32'd0);
        chk("rst_blank", 32'(vif_def.blank), 32'd0);
        chk("rst_hs", 32'(vif_def.hs), 32'd1);
        chk("rst_vs", 32'(vif_def.vs), 32'd1);
        chk("rst_line_start", 32'(vif_def.line_start), 32'd0);
        chk("rst_frame_start", 32'(vif_def.frame_start), 32'd0);
        chk("rst_frame_count", 32'(vif_def.frame_count), 32'd0);

        rst_def = 1'b0;
        #1;
        chk("c0_frame_start", 32'(vif_def.frame_start), 32'd1);
        chk("c0_vs", 32'(vif_def.vs), 32'd1);

        hs_low = 0;
        for (int i = 0; i < 800; i++) begin
            chk("line0_drawx", 32'(vif_def.DrawX), 32'(i));
            chk("line0_drawy", 32'(vif_def.DrawY), 32'd0);
            chk("line0_hs", 32'(vif_def.hs), (i >= 656 && i < 752) ? 32'd0 : 32'd1);
            chk("line0_blank", 32'(vif_def.blank), (i < 640) ? 32'd1 : 32'd0);
            chk("line0_line_start", 32'(vif_def.line_start), (i == 0) ? 32'd1 : 32'd0);
            if (vif_def.hs === 1'b0) hs_low++;
            step();
        end
        chk("line0_hs_low_count", 32'(hs_low), 32'd96);
        chk("line1_drawx", 32'(vif_def.DrawX), 32'd0);
        chk("line1_drawy", 32'(vif_def.DrawY), 32'd1);
        chk("line1_line_start", 32'(vif_def.line_start), 32'd1);
        chk("line1_frame_start", 32'(vif_def.frame_start), 32'd0);
        chk("line1_blank", 32'(vif_def.blank), 32'd1);
        rst_def = 1'b1;

        // ---------------- reduced raster: mid-frame reset ----------------
        rst_med = 1'b0;
        #1;
        chk("med_c0_frame_start", 32'(vif_med.frame_start), 32'd1);
        repeat (202) step();
        chk("med_pre_drawx", 32'(vif_med.DrawX), 32'd10);
        chk("med_pre_drawy", 32'(vif_med.DrawY), 32'd8);
        chk("med_pre_blank", 32'(vif_med.blank), 32'd1);
        chk("med_pre_frame_count", 32'(vif_med.frame_count), 32'd0);

        rst_med = 1'b1;
        #1;
        chk("med_rst_drawx", 32'(vif_med.DrawX), 32'd0);
        chk("med_rst_drawy", 32'(vif_med.DrawY), 32'd0);
        chk("med_rst_blank", 32'(vif_med.blank), 32'd0);
        chk("med_rst_hs", 32'(vif_med.hs), 32'd1);
        chk("med_rst_vs", 32'(vif_med.vs), 32'd1);
        chk("med_rst_frame_start", 32'(vif_med.frame_start), 32'd0);
        @(negedge clk);
        rst_med = 1'b0;
        #1;
        chk("med_post_drawx", 32'(vif_med.DrawX), 32'd0);
        chk("med_post_drawy", 32'(vif_med.DrawY), 32'd0);
        chk("med_post_frame_count", 32'(vif_med.frame_count), 32'd0);
        chk("med_post_frame_start", 32'(vif_med.frame_start), 32'd1);

        // ---------------- reduced raster: one full frame ----------------
        vs_low = 0;
        for (int i = 0; i < 432; i++) begin
            int x;
            int y;
            x = i % 24;
            y = i / 24;
            chk("frm_drawx", 32'(vif_med.DrawX), 32'(x));
            chk("frm_drawy", 32'(vif_med.DrawY), 32'(y));
            chk("frm_hs", 32'(vif_med.hs), (x >= 18 && x < 22) ? 32'd0 : 32'd1);
            chk("frm_vs", 32'(vif_med.vs), (y == 14 || y == 15) ? 32'd0 : 32'd1);
            chk("frm_blank", 32'(vif_med.blank), (x < 16 && y < 12) ? 32'd1 : 32'd0);
            chk("frm_line_start", 32'(vif_med.line_start), (x == 0) ? 32'd1 : 32'd0);
            chk("frm_frame_start", 32'(vif_med.frame_start), (i == 0) ? 32'd1 : 32'd0);
            chk("frm_frame_count", 32'(vif_med.frame_count), 32'd0);
            if (vif_med.vs === 1'b0) vs_low++;
            step();
        end
        chk("frm_vs_low_count", 32'(vs_low), 32'd48);
        chk("frm2_drawx", 32'(vif_med.DrawX), 32'd0);
        chk("frm2_drawy", 32'(vif_med.DrawY), 32'd0);
        chk("frm2_frame_count", 32'(vif_med.frame_count), 32'd1);
        chk("frm2_frame_start", 32'(vif_med.frame_start), 32'd1);
        rst_med = 1'b1;

        // ---------------- 1x1 raster: frame_count wrap ----------------
        rst_tiny = 1'b0;
        #1;
        chk("tiny_c0_frame_count", 32'(vif_tiny.frame_count), 32'd0);
        chk("tiny_c0_frame_start", 32'(vif_tiny.frame_start), 32'd1);
        glitch = 0;
        repeat (65535) begin
            step();
            if (vif_tiny.hs !== 1'b1 || vif_tiny.vs !== 1'b1) glitch++;
        end
        chk("tiny_max_frame_count", 32'(vif_tiny.frame_count), 32'h0000_FFFF);
        chk("tiny_sync_glitches", 32'(glitch), 32'd0);
        step();
        chk("tiny_wrap_frame_count", 32'(vif_tiny.frame_count), 32'd0);
        chk("tiny_wrap_hs", 32'(vif_tiny.hs), 32'd1);
        chk("tiny_wrap_vs", 32'(vif_tiny.vs), 32'd1);
        chk("tiny_wrap_frame_start", 32'(vif_tiny.frame_start), 32'd1);
        rst_tiny = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
